// File: rtl/cell_fetch_pkg.sv
// Shared Lisp machine types: word layout, cell record and the fetch FSM encoding.
// A header word is {mark bit, type}; the mark sits above the type field.
package lisp;

   localparam int word_size = 15;
   localparam int mark_bit  = word_size;

   typedef logic [word_size:0]   word_t;
   typedef logic [word_size-1:0] type_t;

   localparam type_t TYPE_NIL    = type_t'(0);
   localparam type_t TYPE_NUMBER = type_t'(1);
   localparam type_t TYPE_SYMBOL = type_t'(2);
   localparam type_t TYPE_CONS   = type_t'(3);

   typedef struct packed {
      word_t header;
      word_t value;
   } cell_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      VAL  = 2'd2,
      RESP = 2'd3
   } fetch_state_t;

   function automatic logic header_mark(input word_t header);
      return header[mark_bit];
   endfunction

   function automatic type_t header_type(input word_t header);
      return header[word_size-1:0];
   endfunction

endpackage

// File: rtl/cell_fetch.sv
// Reads a two-word cell (header at base, value at base+1) from the synchronous-read
// memory and returns it over a valid/ready response; misaligned or out-of-range bases error out.
module cell_fetch
   import lisp::*;
#(
   parameter int MemSize = 1024
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [word_size:0]   req_addr,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [word_size:0]   rsp_header,
   output logic [word_size:0]   rsp_value,
   output logic                 rsp_error,
   output logic [word_size:0]   mem_addr,
   input  logic [word_size:0]   mem_data,
   output fetch_state_t         fsm_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
   // rsp_valid holds, with stable data, until rsp_ready is seen; req_ready is only high in IDLE.

   localparam logic [word_size:0] last_base = (word_size+1)'(MemSize - 2);
   localparam logic [word_size:0] one       = (word_size+1)'(1);

   fetch_state_t         state;
   fetch_state_t         next_state;
   logic [word_size:0]   base;
   logic [word_size:0]   base_next;
   cell_t                rsp_cell;
   logic                 bad;
   logic                 accept;

   // The range check keeps base <= MemSize-2, so base+1 never wraps.
   assign bad       = req_addr[0] || (req_addr > last_base);
   assign accept    = req_valid && req_ready;
   assign base_next = base + one;

   assign rsp_header = rsp_cell.header;
   assign rsp_value  = rsp_cell.value;
   assign fsm_state  = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         base      <= '0;
         rsp_cell  <= '0;
         rsp_error <= 1'b0;
         rsp_valid <= 1'b0;
      end else begin
         state <= next_state;
         case (state)
            IDLE: begin
               if (accept) begin
                  base <= req_addr;
                  if (bad) begin
                     rsp_cell  <= '0;
                     rsp_error <= 1'b1;
                     rsp_valid <= 1'b1;
                  end
               end
            end
            HDR:  rsp_cell.header <= mem_data;
            VAL: begin
               rsp_cell.value <= mem_data;
               rsp_error      <= 1'b0;
               rsp_valid      <= 1'b1;
            end
            RESP: if (rsp_ready) rsp_valid <= 1'b0;
            default: ;
         endcase
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = bad ? RESP : HDR;
         HDR:     next_state = VAL;
         VAL:     next_state = RESP;
         RESP:    if (rsp_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // The header read is presented in IDLE so memory captures it on the accept edge.
   // A rejected request never drives a real address onto the memory bus.
   always_comb begin
      req_ready = 1'b0;
      mem_addr  = '0;
      if (rst_n) begin
         case (state)
            IDLE: begin
               req_ready = 1'b1;
               mem_addr  = bad ? '0 : req_addr;
            end
            HDR, VAL: mem_addr = base_next;
            RESP:     mem_addr = rsp_error ? '0 : base_next;
            default:  mem_addr = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_cell_fetch.sv
// Bench for cell_fetch: a sync-read memory model, a transaction-level monitor with an
// expected-response queue, directed boundary scenarios and a randomized traffic phase.
module tb_cell_fetch;
   import lisp::*;

   localparam int MemSize = 1024;
   localparam int W       = word_size + 1;

   logic         clk;
   logic         rst_n;
   logic         req_valid;
   logic         req_ready;
   logic [W-1:0] req_addr;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [W-1:0] rsp_header;
   logic [W-1:0] rsp_value;
   logic         rsp_error;
   logic [W-1:0] mem_addr;
   logic [W-1:0] mem_data;
   fetch_state_t fsm_state;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [W-1:0]     mem [0:MemSize-1];
   logic [2*W:0]     exp_q [$];
   int               acc_q [$];
   int               hs_q [$];

   int               rdy_mode = 0;
   logic             rdy_force = 1'b1;
   logic             rand_rdy = 1'b0;

   cell_fetch #(.MemSize(MemSize)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_header (rsp_header),
      .rsp_value  (rsp_value),
      .rsp_error  (rsp_error),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .fsm_state  (fsm_state)
   );

   // ---------------- clock / reset / environment ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk)
      mem_data <= (int'(mem_addr) < MemSize) ? mem[int'(mem_addr)] : 16'hDEAD;

   assign rsp_ready = (rdy_mode == 1) ? rand_rdy : rdy_force;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         rand_rdy = 1'($urandom_range(0, 1));
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic model_bad(input int a);
      return (a % 2 == 1) || (a + 1 >= MemSize);
   endfunction

   // ---------------- monitor / scoreboard ----------------
   logic         busy = 1'b0;
   logic         seen_valid = 1'b0;
   int           acc_cyc = 0;
   int           exp_lat = 0;
   logic [W-1:0] exp_ma = '0;
   logic [2*W:0] last_rsp = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         busy     = 1'b0;
         last_rsp = '0;
      end else if (busy) begin
         check("mem_addr_busy", mem_addr, exp_ma);
         check("req_ready_busy", req_ready, 1'b0);
         if (!rsp_valid) begin
            check("rsp_valid_early", 64'(cyc - acc_cyc < exp_lat), 1);
         end else begin
            if (!seen_valid) begin
               check("latency", 64'(cyc - acc_cyc), 64'(exp_lat));
               seen_valid = 1'b1;
            end
            check("rsp_error",  rsp_error,  exp_q[0][2*W]);
            check("rsp_header", rsp_header, exp_q[0][2*W-1:W]);
            check("rsp_value",  rsp_value,  exp_q[0][W-1:0]);
            if (rsp_ready) begin
               last_rsp = exp_q.pop_front();
               busy     = 1'b0;
               hs_q.push_back(cyc);
            end
         end
      end else begin
         check("req_ready_idle", req_ready, 1'b1);
         check("rsp_valid_idle", rsp_valid, 1'b0);
         check("rsp_retained", {rsp_error, rsp_header, rsp_value}, last_rsp);
         check("mem_addr_idle", mem_addr, model_bad(int'(req_addr)) ? '0 : req_addr);
         if (req_valid) begin
            int a;
            a = int'(req_addr);
            if (model_bad(a)) begin
               exp_q.push_back({1'b1, {(2*W){1'b0}}});
               exp_lat = 1;
               exp_ma  = '0;
            end else begin
               exp_q.push_back({1'b0, mem[a], mem[a+1]});
               exp_lat = 3;
               exp_ma  = W'(a + 1);
            end
            busy       = 1'b1;
            seen_valid = 1'b0;
            acc_cyc    = cyc;
            acc_q.push_back(cyc);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [W-1:0] addr);
      logic acc;
      acc = 1'b0;
      req_valid = 1'b1;
      req_addr  = addr;
      for (int i = 0; i < 200 && !acc; i++) begin
         @(negedge clk);
         acc = req_ready;
         @(posedge clk);
         #1;
      end
      if (!acc) check("send_timeout", acc, 1'b1);
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp();
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = rsp_valid;
      end
      if (!seen) check("rsp_timeout", rsp_valid, 1'b1);
   endtask

   task automatic wait_idle();
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(posedge clk);
         #1;
         ok = req_ready && (exp_q.size() == 0);
      end
      if (!ok) check("idle_timeout", req_ready, 1'b1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [W-1:0] h0, v0;
      logic         acc;
      int           n0;

      for (int i = 0; i < MemSize; i++) mem[i] = W'($urandom);
      mem[0] = {1'b0, TYPE_NUMBER};
      mem[1] = 16'h2A2A;

      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_addr  = '0;
      #1;
      check("rst_req_ready",  req_ready,  1'b0);
      check("rst_rsp_valid",  rsp_valid,  1'b0);
      check("rst_rsp_header", rsp_header, '0);
      check("rst_rsp_value",  rsp_value,  '0);
      check("rst_rsp_error",  rsp_error,  1'b0);
      check("rst_mem_addr",   mem_addr,   '0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // First cell: number 0x2A2A at address 0.
      send(16'd0);
      wait_rsp();
      check("t1_header", rsp_header, {1'b0, TYPE_NUMBER});
      check("t1_value",  rsp_value,  16'h2A2A);
      check("t1_error",  rsp_error,  1'b0);
      wait_idle();

      // Misaligned base.
      send(16'd1);
      wait_rsp();
      check("odd_error",  rsp_error,  1'b1);
      check("odd_header", rsp_header, '0);
      check("odd_value",  rsp_value,  '0);
      wait_idle();

      // Top boundary: last legal cell, then one past it.
      send(16'(MemSize - 2));
      wait_rsp();
      check("top_header", rsp_header, mem[MemSize-2]);
      check("top_value",  rsp_value,  mem[MemSize-1]);
      check("top_error",  rsp_error,  1'b0);
      wait_idle();
      send(16'(MemSize));
      wait_rsp();
      check("over_error", rsp_error, 1'b1);
      wait_idle();
      send(16'(MemSize - 1));
      wait_idle();

      // Backpressure: response held for 5 cycles while a new request waits.
      rdy_mode  = 2;
      rdy_force = 1'b0;
      send(16'd4);
      wait_rsp();
      h0 = rsp_header;
      v0 = rsp_value;
      @(posedge clk);
      #1;
      req_valid = 1'b1;
      req_addr  = 16'd6;
      repeat (5) begin
         @(negedge clk);
         check("bp_valid",     rsp_valid,  1'b1);
         check("bp_req_ready", req_ready,  1'b0);
         check("bp_header",    rsp_header, h0);
         check("bp_value",     rsp_value,  v0);
      end
      @(posedge clk);
      #1;
      rdy_force = 1'b1;
      acc = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) begin
         @(negedge clk);
         acc = req_ready;
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      check("bp_accepted", acc, 1'b1);
      if (acc) check("bp_accept_gap", 64'(acc_q[$] - hs_q[$]), 1);
      wait_idle();

      // Back-to-back with the consumer always ready.
      rdy_mode  = 0;
      rdy_force = 1'b1;
      n0 = acc_q.size();
      send(16'd0);
      send(16'd2);
      send(16'd4);
      wait_idle();
      check("b2b_count", 64'(acc_q.size() - n0), 3);
      if (acc_q.size() - n0 == 3) begin
         check("b2b_gap0", 64'(acc_q[n0+1] - acc_q[n0]),   4);
         check("b2b_gap1", 64'(acc_q[n0+2] - acc_q[n0+1]), 4);
      end

      // Reset while the value word is being read.
      send(16'd8);
      @(posedge clk);
      #2;
      check("pre_rst_state", fsm_state, VAL);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid",     rsp_valid,  1'b0);
      check("mid_rst_header",    rsp_header, '0);
      check("mid_rst_value",     rsp_value,  '0);
      check("mid_rst_error",     rsp_error,  1'b0);
      check("mid_rst_req_ready", req_ready,  1'b0);
      check("mid_rst_mem_addr",  mem_addr,   '0);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_req_ready", req_ready, 1'b1);
      repeat (5) begin
         @(negedge clk);
         check("post_rst_no_rsp", rsp_valid, 1'b0);
      end
      @(posedge clk);
      #1;

      // Randomized traffic with a randomly stalling consumer.
      rdy_mode = 1;
      for (int k = 0; k < 60; k++) begin
         int cat;
         logic [W-1:0] a;
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
         cat = int'($urandom_range(0, 9));
         case (cat)
            0, 1, 2, 3, 4, 5: a = W'(2 * $urandom_range(0, MemSize/2 - 1));
            6:                a = W'(2 * $urandom_range(0, MemSize/2 - 1) + 1);
            7:                a = W'(MemSize - 2);
            8:                a = W'(MemSize + $urandom_range(0, 7));
            default:          a = W'($urandom_range(0, 65535));
         endcase
         send(a);
      end
      rdy_mode = 0;
      wait_idle();
      check("drain", 64'(exp_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
